// File: rtl/imem_loader.sv
// Instruction-memory loader: packs a little-endian byte stream into 32-bit words and
// writes them to instruction memory while holding the CPU in stall.
module imem_loader #(
    parameter int N  = 2048,
    parameter int LW = 12
) (
    input  logic          i_clk,
    input  logic          i_reset,
    input  logic          i_load_start,
    input  logic [LW-1:0] i_load_len,
    input  logic          i_abort,
    input  logic          i_byte_valid,
    input  logic [7:0]    i_byte_data,
    output logic          o_byte_ready,
    output logic          o_imem_we,
    output logic [31:0]   o_imem_waddr,
    output logic [31:0]   o_imem_wdata,
    output logic          o_cpu_stall,
    output logic          o_load_done,
    output logic          o_load_err
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RECV  = 2'd1,
        S_WRITE = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic [LW:0] C_DEPTH = (LW+1)'(N);

    state_t        r_state;
    state_t        w_state_nxt;
    logic [LW-1:0] r_len;
    logic [LW-1:0] r_word_idx;
    logic [1:0]    r_byte_idx;
    logic [31:0]   r_word;
    logic          r_err;

    logic          w_len_ok;
    logic          w_byte_xfer;
    logic [LW-1:0] w_word_idx_inc;
    logic          w_last_word;

    // Places one byte into its little-endian lane of the word being assembled.
    function automatic logic [31:0] f_pack_byte(
        input logic [31:0] word,
        input logic [1:0]  idx,
        input logic [7:0]  data
    );
        logic [31:0] res;
        res = word;
        case (idx)
            2'd0:    res[7:0]   = data;
            2'd1:    res[15:8]  = data;
            2'd2:    res[23:16] = data;
            2'd3:    res[31:24] = data;
            default: res        = word;
        endcase
        return res;
    endfunction

    assign w_len_ok       = (i_load_len != {LW{1'b0}}) && ({1'b0, i_load_len} <= C_DEPTH);
    assign w_byte_xfer    = (r_state == S_RECV) && i_byte_valid;
    assign w_word_idx_inc = r_word_idx + {{(LW-1){1'b0}}, 1'b1};
    assign w_last_word    = (w_word_idx_inc == r_len);

    // State register.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic; abort outranks byte transfers and the write.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (i_load_start && w_len_ok) begin
                    w_state_nxt = S_RECV;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_RECV: begin
                if (i_abort) begin
                    w_state_nxt = S_IDLE;
                end else if (w_byte_xfer && (r_byte_idx == 2'd3)) begin
                    w_state_nxt = S_WRITE;
                end else begin
                    w_state_nxt = S_RECV;
                end
            end
            S_WRITE: begin
                if (i_abort) begin
                    w_state_nxt = S_IDLE;
                end else if (w_last_word) begin
                    w_state_nxt = S_DONE;
                end else begin
                    w_state_nxt = S_RECV;
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Datapath: length latch, word/byte indices, word assembly and sticky error.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_len      <= {LW{1'b0}};
            r_word_idx <= {LW{1'b0}};
            r_byte_idx <= 2'd0;
            r_word     <= 32'd0;
            r_err      <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_load_start) begin
                        if (w_len_ok) begin
                            r_err      <= 1'b0;
                            r_len      <= i_load_len;
                            r_word_idx <= {LW{1'b0}};
                            r_byte_idx <= 2'd0;
                        end else begin
                            r_err <= 1'b1;
                        end
                    end
                end
                S_RECV: begin
                    if (i_abort) begin
                        r_err      <= 1'b1;
                        r_byte_idx <= 2'd0;
                    end else if (w_byte_xfer) begin
                        r_word     <= f_pack_byte(r_word, r_byte_idx, i_byte_data);
                        r_byte_idx <= r_byte_idx + 2'd1;
                    end
                end
                S_WRITE: begin
                    if (i_abort) begin
                        r_err <= 1'b1;
                    end else if (!w_last_word) begin
                        r_word_idx <= w_word_idx_inc;
                    end
                end
                S_DONE: begin
                    r_err <= r_err;
                end
                default: begin
                    r_err <= r_err;
                end
            endcase
        end
    end

    // The write strobe is gated by abort so an abort in WRITE suppresses that cycle's write.
    assign o_byte_ready = (r_state == S_RECV);
    assign o_imem_we    = (r_state == S_WRITE) && !i_abort;
    assign o_imem_waddr = {{(30-LW){1'b0}}, r_word_idx, 2'b00};
    assign o_imem_wdata = r_word;
    assign o_cpu_stall  = (r_state != S_IDLE);
    assign o_load_done  = (r_state == S_DONE);
    assign o_load_err   = r_err;

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: expected writes are queued as bytes are driven and
// compared when the write strobe is seen.
module tb_imem_loader;

    localparam int N  = 2048;
    localparam int LW = 12;

    logic          i_clk = 1'b0;
    logic          i_reset;
    logic          i_load_start;
    logic [LW-1:0] i_load_len;
    logic          i_abort;
    logic          i_byte_valid;
    logic [7:0]    i_byte_data;
    logic          o_byte_ready;
    logic          o_imem_we;
    logic [31:0]   o_imem_waddr;
    logic [31:0]   o_imem_wdata;
    logic          o_cpu_stall;
    logic          o_load_done;
    logic          o_load_err;

    int          n_checks = 0;
    int          n_fail   = 0;
    int          cyc      = 0;
    int          wr_cnt   = 0;
    int          done_cnt = 0;
    int          last_acc = 0;
    logic [63:0] exp_q[$];

    imem_loader #(.N(N), .LW(LW)) dut (
        .i_clk        (i_clk),
        .i_reset      (i_reset),
        .i_load_start (i_load_start),
        .i_load_len   (i_load_len),
        .i_abort      (i_abort),
        .i_byte_valid (i_byte_valid),
        .i_byte_data  (i_byte_data),
        .o_byte_ready (o_byte_ready),
        .o_imem_we    (o_imem_we),
        .o_imem_waddr (o_imem_waddr),
        .o_imem_wdata (o_imem_wdata),
        .o_cpu_stall  (o_cpu_stall),
        .o_load_done  (o_load_done),
        .o_load_err   (o_load_err)
    );

    always #5 i_clk = ~i_clk;

    always @(posedge i_clk) cyc <= cyc + 1;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Write monitor: pops the scoreboard on every strobe.
    always @(negedge i_clk) begin
        logic [63:0] exp_w;
        if (o_load_done === 1'b1) done_cnt++;
        if (o_imem_we === 1'b1) begin
            wr_cnt++;
            exp_w = (exp_q.size() > 0) ? exp_q.pop_front() : 64'hDEAD_BEEF_DEAD_BEEF;
            check_val("imem_write", {o_imem_waddr, o_imem_wdata}, exp_w);
            check_val("waddr_bound", 64'(o_imem_waddr < 32'(N * 4)), 64'd1);
        end
    end

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic start_load(input int len);
        i_load_start = 1'b1;
        i_load_len   = LW'(len);
        tick();
        i_load_start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input bit rnd);
        int g = 0;
        if (rnd) begin
            while ($urandom_range(0, 1) == 0 && g < 5) begin
                i_byte_valid = 1'b0;
                i_byte_data  = 8'($urandom);
                tick();
                g++;
            end
        end
        i_byte_valid = 1'b1;
        i_byte_data  = b;
        g = 0;
        while (o_byte_ready !== 1'b1 && g < 20) begin
            tick();
            g++;
        end
        if (g >= 20) check_val("byte_ready_timeout", {63'd0, o_byte_ready}, 64'd1);
        last_acc = cyc;
        tick();
        i_byte_valid = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w, input bit rnd);
        for (int k = 0; k < 4; k++) send_byte(w[8*k +: 8], rnd);
    endtask

    task automatic wait_done(output int dcyc);
        int g = 0;
        while (o_load_done !== 1'b1 && g < 100) begin
            tick();
            g++;
        end
        check_val("done_seen", {63'd0, o_load_done}, 64'd1);
        dcyc = cyc;
    endtask

    task automatic check_reset_outputs(input string tag);
        check_val({tag, "_ready"}, {63'd0, o_byte_ready}, 64'd0);
        check_val({tag, "_we"},    {63'd0, o_imem_we},    64'd0);
        check_val({tag, "_waddr"}, {32'd0, o_imem_waddr}, 64'd0);
        check_val({tag, "_wdata"}, {32'd0, o_imem_wdata}, 64'd0);
        check_val({tag, "_stall"}, {63'd0, o_cpu_stall},  64'd0);
        check_val({tag, "_done"},  {63'd0, o_load_done},  64'd0);
        check_val({tag, "_err"},   {63'd0, o_load_err},   64'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          c0;
        int          dc;
        int          wr0;
        int          dn0;
        logic [31:0] w;

        i_reset = 1'b1; i_load_start = 1'b0; i_load_len = '0; i_abort = 1'b0;
        i_byte_valid = 1'b0; i_byte_data = 8'h00;
        repeat (3) tick();
        check_reset_outputs("reset");
        i_reset = 1'b0;
        tick();

        // Abort in IDLE is inert.
        i_abort = 1'b1; tick(); i_abort = 1'b0;
        check_val("idle_abort_err", {63'd0, o_load_err}, 64'd0);

        // Single-word load.
        start_load(1);
        check_val("len1_stall", {63'd0, o_cpu_stall}, 64'd1);
        exp_q.push_back({32'h0, 32'h0000_0013});
        send_word(32'h0000_0013, 1'b0);
        wait_done(dc);
        tick();
        check_val("len1_stall_after", {63'd0, o_cpu_stall}, 64'd0);
        check_val("len1_done_pulse",  {63'd0, o_load_done}, 64'd0);
        check_val("len1_q_empty", 64'(exp_q.size()), 64'd0);

        // Two words, bytes every cycle; done ten cycles after first accept.
        start_load(2);
        exp_q.push_back({32'h0, 32'h0010_0093});
        exp_q.push_back({32'h4, 32'h0020_0113});
        send_byte(8'h93, 1'b0);
        c0 = last_acc;
        send_byte(8'h00, 1'b0); send_byte(8'h10, 1'b0); send_byte(8'h00, 1'b0);
        send_word(32'h0020_0113, 1'b0);
        wait_done(dc);
        check_val("len2_done_latency", 64'(dc - c0), 64'd10);
        check_val("len2_q_empty", 64'(exp_q.size()), 64'd0);
        tick();

        // Illegal lengths.
        wr0 = wr_cnt;
        start_load(0);
        check_val("len0_err", {63'd0, o_load_err}, 64'd1);
        check_val("len0_stall", {63'd0, o_cpu_stall}, 64'd0);
        tick();
        start_load(N + 1);
        check_val("lenN1_err", {63'd0, o_load_err}, 64'd1);
        tick();
        check_val("lenN1_stall", {63'd0, o_cpu_stall}, 64'd0);
        check_val("bad_len_no_write", 64'(wr_cnt - wr0), 64'd0);
        start_load(1);
        check_val("err_cleared", {63'd0, o_load_err}, 64'd0);
        exp_q.push_back({32'h0, 32'hCAFE_F00D});
        send_word(32'hCAFE_F00D, 1'b0);
        wait_done(dc);
        tick();

        // Random valid gaps, three words.
        wr0 = wr_cnt;
        start_load(3);
        for (int i = 0; i < 3; i++) begin
            w = $urandom;
            exp_q.push_back({32'(i * 4), w});
            send_word(w, 1'b1);
        end
        wait_done(dc);
        check_val("rnd_write_count", 64'(wr_cnt - wr0), 64'd3);
        check_val("rnd_q_empty", 64'(exp_q.size()), 64'd0);
        tick();

        // Abort mid-word with an ignored restart request.
        wr0 = wr_cnt;
        dn0 = done_cnt;
        start_load(4);
        exp_q.push_back({32'h0, 32'h1122_3344});
        send_word(32'h1122_3344, 1'b0);
        start_load(1);
        send_byte(8'hAA, 1'b0);
        send_byte(8'hBB, 1'b0);
        i_abort = 1'b1; tick(); i_abort = 1'b0;
        check_val("abort_err",   {63'd0, o_load_err},   64'd1);
        check_val("abort_stall", {63'd0, o_cpu_stall},  64'd0);
        check_val("abort_ready", {63'd0, o_byte_ready}, 64'd0);
        repeat (8) tick();
        check_val("abort_writes", 64'(wr_cnt - wr0), 64'd1);
        check_val("abort_no_done", 64'(done_cnt - dn0), 64'd0);

        // Abort exactly in WRITE suppresses that write.
        wr0 = wr_cnt;
        start_load(2);
        send_word(32'h5566_7788, 1'b0);
        i_abort = 1'b1; tick(); i_abort = 1'b0;
        check_val("wabort_writes", 64'(wr_cnt - wr0), 64'd0);
        check_val("wabort_err",    {63'd0, o_load_err},  64'd1);
        check_val("wabort_stall",  {63'd0, o_cpu_stall}, 64'd0);
        tick();

        // Reset during the WRITE of the fifth word.
        dn0 = done_cnt;
        start_load(8);
        for (int i = 0; i < 5; i++) begin
            w = 32'hA000_0000 | 32'(i);
            exp_q.push_back({32'(i * 4), w});
            send_word(w, 1'b0);
        end
        check_val("w5_in_write", {63'd0, o_imem_we}, 64'd1);
        i_reset = 1'b1;
        tick();
        check_reset_outputs("midreset");
        tick();
        i_reset = 1'b0;
        wr0 = wr_cnt;
        repeat (6) tick();
        check_val("midreset_no_write", 64'(wr_cnt - wr0), 64'd0);
        check_val("midreset_no_done", 64'(done_cnt - dn0), 64'd0);
        check_val("final_q_empty", 64'(exp_q.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
